// File: rtl/ysyx_23060077_riscv_if_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ysyx_23060077_riscv_if_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060077_riscv_if_fetch.sv
// Instruction fetch unit: owns the PC, one outstanding imem read, delivers {pc, inst, err} to ID.
// Optional macro YSYX_23060077_IFU_MISALIGN_EN reports misaligned fetch targets instead of aligning them.
module ysyx_23060077_riscv_if_fetch
  import ysyx_23060077_riscv_if_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_err,
  output logic            if_misalign
);

  ifu_state_e      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] req_addr_q, req_addr_nxt;
  logic [XLEN-1:0] if_pc_q, if_pc_nxt;
  logic [31:0]     inst_q, inst_nxt;
  logic            err_q, err_nxt;
  logic            mis_q, mis_nxt;
  logic            kill, kill_nxt;
  logic [XLEN-1:0] redir_tgt;
  logic            req_mis;

`ifdef YSYX_23060077_IFU_MISALIGN_EN
  assign redir_tgt = redirect_pc;
  assign req_mis   = (req_addr_q[1:0] != 2'b00);
`else
  assign redir_tgt = redirect_pc & ~XLEN'(3);
  assign req_mis   = 1'b0;
`endif

  // req_addr_q is the address on the bus; pc may move ahead of it on a redirect
  // while a request is mid-handshake, in which case kill marks the response as stale.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr_q;
    kill_nxt     = kill;
    if_pc_nxt    = if_pc_q;
    inst_nxt     = inst_q;
    err_nxt      = err_q;
    mis_nxt      = mis_q;
    if (redirect_valid) pc_nxt = redir_tgt;
    case (state)
      S_REQ: begin
        if (req_mis) begin
          if (redirect_valid) begin
            req_addr_nxt = redir_tgt;
          end else begin
            state_nxt = S_OUT;
            if_pc_nxt = req_addr_q;
            inst_nxt  = '0;
            err_nxt   = 1'b0;
            mis_nxt   = 1'b1;
          end
        end else begin
          if (redirect_valid) kill_nxt = 1'b1;
          if (imem_req_ready) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill || redirect_valid) begin
            state_nxt    = S_REQ;
            kill_nxt     = 1'b0;
            req_addr_nxt = pc_nxt;
          end else begin
            state_nxt = S_OUT;
            if_pc_nxt = req_addr_q;
            inst_nxt  = imem_rsp_data;
            err_nxt   = imem_rsp_err;
            mis_nxt   = 1'b0;
          end
        end else if (redirect_valid) begin
          kill_nxt = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid || if_ready) begin
          state_nxt = S_REQ;
          if (!redirect_valid) pc_nxt = pc + XLEN'(4);
          req_addr_nxt = pc_nxt;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill       <= 1'b0;
      if_pc_q    <= '0;
      inst_q     <= '0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_addr_q <= req_addr_nxt;
      kill       <= kill_nxt;
      if_pc_q    <= if_pc_nxt;
      inst_q     <= inst_nxt;
      err_q      <= err_nxt;
      mis_q      <= mis_nxt;
    end
  end

  assign imem_req_valid = !rst && (state == S_REQ) && !req_mis;
  assign imem_req_addr  = req_addr_q;
  assign imem_rsp_ready = (state == S_WAIT);
  assign if_valid       = (state == S_OUT);
  assign if_pc          = if_pc_q;
  assign if_inst        = inst_q;
  assign if_err         = err_q;
  assign if_misalign    = mis_q;

endmodule

// File: tb/tb_ysyx_23060077_riscv_if_fetch.sv
// Self-checking bench for the fetch unit: directed scenarios followed by random traffic,
// with a program-order model of which PC must be delivered next.
module tb_ysyx_23060077_riscv_if_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_err;
  logic        if_misalign;

  always #5 clk = ~clk;

  ysyx_23060077_riscv_if_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_err(if_err), .if_misalign(if_misalign)
  );

  int checks = 0;
  int errors = 0;

  bit          outst;
  logic [31:0] out_addr;
  int          delay;
  bit          use_nop;
  logic [31:0] err_addr;
  bit          rand_err;

  logic [31:0] exp_pc;
  int          delivered = 0;
  bit          redir_prev, hold_prev, req_pend;
  logic [31:0] hold_pc, hold_inst, pend_addr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return use_nop ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A);
  endfunction

  function automatic bit errfn(input logic [31:0] a);
    return (a == err_addr) || (rand_err && a[6:2] == 5'd7);
  endfunction

  function automatic logic [31:0] tgtfn(input logic [31:0] t);
`ifdef YSYX_23060077_IFU_MISALIGN_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance to next negedge.
  task automatic tick(input bit rq, input bit ir, input bit rv, input logic [31:0] rt, input int lat);
    bit mis;
    imem_req_ready = rq;
    if_ready       = ir;
    redirect_valid = rv;
    redirect_pc    = rt;
    imem_rsp_valid = outst && (delay == 0);
    imem_rsp_data  = imem_rsp_valid ? memfn(out_addr) : 32'hDEAD_BEEF;
    imem_rsp_err   = imem_rsp_valid && errfn(out_addr);
    #1;
    if (redir_prev) chk("if_valid_after_redirect", if_valid, 0);
    if (req_pend) chk("req_addr_held", {imem_req_valid, imem_req_addr}, {1'b1, pend_addr});
    if (hold_prev) chk("if_hold", {if_valid, if_pc, if_inst}, {1'b1, hold_pc, hold_inst});
    if (if_valid && if_ready) begin
      mis = (exp_pc[1:0] != 2'b00);
      chk("if_pc", if_pc, exp_pc);
      chk("if_inst", if_inst, mis ? 32'h0 : memfn(exp_pc));
      chk("if_err_mis", {if_err, if_misalign}, {!mis && errfn(exp_pc), mis});
      exp_pc += 32'd4;
      delivered++;
    end
    if (rv) exp_pc = tgtfn(rt);
    redir_prev = rv;
    hold_prev  = if_valid && !if_ready && !rv;
    hold_pc    = if_pc;
    hold_inst  = if_inst;
    req_pend   = imem_req_valid && !imem_req_ready;
    pend_addr  = imem_req_addr;
    if (imem_rsp_valid && imem_rsp_ready) outst = 0;
    else if (outst && delay > 0) delay--;
    if (imem_req_valid && imem_req_ready) begin
      chk("one_outstanding", outst, 0);
      outst    = 1;
      out_addr = imem_req_addr;
      delay    = lat;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    outst      = 0;
    redir_prev = 0;
    hold_prev  = 0;
    req_pend   = 0;
    #1;
    chk("rst_outputs",
        {imem_req_valid, imem_rsp_ready, if_valid, if_err, if_misalign, if_pc, if_inst}, '0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    exp_pc = RST_PC;
    #1;
  endtask

  task automatic run_to_out(input int lat);
    int n = 0;
    while (!if_valid && n < 20) begin
      tick(1, 0, 0, 32'h0, lat);
      n++;
    end
    chk("reach_out", if_valid, 1);
  endtask

  initial begin
    imem_req_ready = 0; if_ready = 0; redirect_valid = 0; redirect_pc = '0;
    imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
    use_nop = 1; err_addr = 32'hFFFF_FFFF; rand_err = 0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // zero-wait memory: one instruction every third cycle
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0)
        chk("t1_req_addr", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC + 32'(4 * (i / 3))});
      chk("t1_if_valid", if_valid, (i % 3 == 2));
      tick(1, 1, 0, 32'h0, 0);
    end

    // ID stall: output held, no new request
    use_nop = 0;
    run_to_out(0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_no_req", imem_req_valid, 0);
      chk("t2_pc", if_pc, RST_PC + 32'h0C);
      tick(1, 0, 0, 32'h0, 0);
    end
    tick(1, 1, 0, 32'h0, 0);
    chk("t2_next_addr", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC + 32'h10});

    // redirect during S_WAIT, response two cycles later
    tick(1, 0, 0, 32'h0, 2);
    for (int i = 0; i < 3; i++) begin
      chk("t3_if_valid", if_valid, 0);
      tick(1, 0, (i == 0), RST_PC + 32'h100, 0);
    end
    chk("t3_addr", {if_valid, imem_req_valid, imem_req_addr}, {2'b01, RST_PC + 32'h100});

    // redirect with if_ready in S_OUT
    run_to_out(0);
    tick(1, 1, 1, RST_PC + 32'h200, 0);
    chk("t4_addr", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC + 32'h200});

    // redirect in S_REQ while memory stalls
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC + 32'h200});
      tick(0, 0, (i == 0), RST_PC + 32'h300, 0);
    end
    tick(1, 0, 0, 32'h0, 0);
    chk("t4_stale_valid", if_valid, 0);
    tick(1, 0, 0, 32'h0, 0);
    chk("t4_refetch", {if_valid, imem_req_valid, imem_req_addr}, {2'b01, RST_PC + 32'h300});
    run_to_out(0);
    tick(1, 1, 0, 32'h0, 0);

    // access fault at 8000_0008
    err_addr = RST_PC + 32'h08;
    run_to_out(0);
    tick(1, 1, 1, RST_PC + 32'h08, 0);
    run_to_out(0);
    chk("t5_err", {if_err, if_pc}, {1'b1, RST_PC + 32'h08});
    tick(1, 1, 0, 32'h0, 0);
    run_to_out(0);
    chk("t5_next", {if_err, if_pc}, {1'b0, RST_PC + 32'h0C});
    tick(1, 1, 0, 32'h0, 0);

    // misaligned redirect target
    run_to_out(0);
    tick(1, 1, 1, RST_PC + 32'h102, 0);
`ifdef YSYX_23060077_IFU_MISALIGN_EN
    chk("t6_noreq", imem_req_valid, 0);
    tick(1, 0, 0, 32'h0, 0);
    chk("t6_mis", {if_valid, if_misalign, if_pc, if_inst}, {2'b11, RST_PC + 32'h102, 32'h0});
    tick(1, 0, 1, RST_PC + 32'h400, 0);
`else
    chk("t6_addr", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC + 32'h100});
`endif

    // reset pulse while a response is outstanding
    tick(1, 0, 0, 32'h0, 3);
    chk("t6_in_wait", imem_rsp_ready, 1);
    do_reset();
    chk("post_rst_addr", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC});

    // random traffic
    rand_err = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = RST_PC + ($urandom_range(0, 255) << 2);
`ifndef YSYX_23060077_IFU_MISALIGN_EN
      tgt[1:0] = 2'($urandom_range(0, 3));
`endif
      tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 19) == 0), tgt, int'($urandom_range(0, 3)));
    end
    chk("progress", (delivered > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
